// File: rtl/accumulator_core_if.sv
// Run handshake plus instruction/data memory bus between accumulator_core and its surroundings.
// slave = the core; master = chip top / ROM / data memory side.
interface accumulator_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 12
);
    logic                  req;
    logic                  done;
    logic [PC_WIDTH-1:0]   instr_addr;
    logic [8:0]            instr_data;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] acc_out;
    logic [31:0]           cycle_count;

    modport slave (
        input  req, instr_data, mem_rdata,
        output done, instr_addr, mem_addr, mem_wdata, mem_we, acc_out, cycle_count
    );

    modport master (
        output req, instr_data, mem_rdata,
        input  done, instr_addr, mem_addr, mem_wdata, mem_we, acc_out, cycle_count
    );
endinterface

// File: rtl/accumulator_core.sv
// Multi-cycle accumulator core: PC, register file, acc, compare flag, IDLE/EXEC/MEM_WAIT/DONE sequencer.
// Optional cycle counter enabled by defining ACC_CORE_PERF_EN.
module accumulator_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 12,
    parameter int REG_COUNT  = 8,
    parameter int START_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    accumulator_core_if.slave   bus
);
    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [3:0] OP_NOP = 4'd0,  OP_LDA = 4'd1,  OP_STA = 4'd2,  OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_LDM = 4'd10, OP_STM  = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12, OP_BEQ = 4'd13, OP_JMP = 4'd14, OP_HALT = 4'd15;

    typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  flag_q, flag_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic                  mem_we;

    logic [3:0]            opcode, field;
    logic                  imm, idx_ok;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] reg_rd, operand;

    assign opcode  = bus.instr_data[8:5];
    assign imm     = bus.instr_data[4];
    assign field   = bus.instr_data[3:0];
    assign idx     = field[IDX_W-1:0];
    assign idx_ok  = int'(idx) < REG_COUNT;
    assign reg_rd  = idx_ok ? regs_q[idx] : '0;
    assign operand = imm ? DATA_WIDTH'(field) : reg_rd;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        flag_d     = flag_q;
        mem_addr_d = mem_addr_q;
        regs_d     = regs_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    pc_d    = PC_WIDTH'(START_ADDR);
                    flag_d  = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d = pc_q + PC_WIDTH'(1);
                case (opcode)
                    OP_NOP: ;
                    OP_LDA: acc_d = operand;
                    OP_STA: if (idx_ok) regs_d[idx] = acc_q;
                    OP_ADD: acc_d = acc_q + operand;
                    OP_SUB: acc_d = acc_q - operand;
                    OP_AND: acc_d = acc_q & operand;
                    OP_OR:  acc_d = acc_q | operand;
                    OP_XOR: acc_d = acc_q ^ operand;
                    OP_SHL: acc_d = acc_q << 1;
                    OP_SHR: acc_d = acc_q >> 1;
                    OP_LDM: begin
                        // PC advances in MEM_WAIT once the read data lands
                        mem_addr_d = operand;
                        pc_d       = pc_q;
                        state_d    = MEM_WAIT;
                    end
                    OP_STM: begin
                        mem_addr_d = operand;
                        mem_we     = 1'b1;
                    end
                    OP_CMP: flag_d = (acc_q == operand);
                    OP_BEQ: if (flag_q) pc_d = pc_q + PC_WIDTH'($signed(field));
                    OP_JMP: pc_d = PC_WIDTH'(reg_rd);
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = DONE;
                    end
                    default: ;
                endcase
            end
            MEM_WAIT: begin
                acc_d   = bus.mem_rdata;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = EXEC;
            end
            DONE: if (!bus.req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= PC_WIDTH'(START_ADDR);
            acc_q      <= '0;
            flag_q     <= 1'b0;
            mem_addr_q <= '0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            flag_q     <= flag_d;
            mem_addr_q <= mem_addr_d;
            regs_q     <= regs_d;
        end
    end

    // Address is live in the LDM/STM cycle and held from the register otherwise
    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_we     = mem_we;
    assign bus.mem_wdata  = acc_q;
    assign bus.acc_out    = acc_q;
    assign bus.instr_addr = pc_q;
    assign bus.done       = (state_q == DONE);

`ifdef ACC_CORE_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && bus.req)
            cyc_d = '0;
        else if ((state_q == EXEC || state_q == MEM_WAIT) && cyc_q != '1)
            cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign bus.cycle_count = cyc_q;
`else
    assign bus.cycle_count = '0;
`endif
endmodule
